// File: rtl/score_disp_pkg.sv
// Shared definitions for the score display colour path: pixel type codes,
// palette index offsets and the default hue table.
package score_disp_pkg;

  typedef enum logic [1:0] {
    PixNote       = 2'b00,
    PixStaff      = 2'b01,
    PixCursor     = 2'b10,
    PixBackground = 2'b11
  } pix_type_e;

  // Fixed palette entries sit directly after the instrument entries.
  localparam int unsigned STAFF_OFS  = 0;
  localparam int unsigned CURSOR_OFS = 1;
  localparam int unsigned BG_OFS     = 2;
  localparam int unsigned NUM_FIXED  = 3;

  // 8-bit-per-channel default colour for instrument i.
  function automatic logic [23:0] hue_rgb24(input int unsigned i);
    case (i)
      0:       return 24'hFF0000;
      1:       return 24'h00FF00;
      2:       return 24'h0000FF;
      3:       return 24'hFFFF00;
      4:       return 24'hFF00FF;
      5:       return 24'h00FFFF;
      6:       return 24'hFF8000;
      7:       return 24'h8000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Reset value of palette entry idx, before scaling to the channel width.
  function automatic logic [23:0] default_rgb24(input int unsigned idx,
                                                input int unsigned num_instr);
    if (idx < num_instr) begin
      return hue_rgb24(idx);
    end else if (idx == num_instr + BG_OFS) begin
      return 24'h000000;
    end else begin
      return 24'hFFFFFF;
    end
  endfunction

endpackage

// File: rtl/color_palette_pipe_if.sv
// Pixel stream, palette write port and colour output of the palette stage.
interface color_palette_pipe_if #(
  parameter int unsigned NUM_INSTR = 4,
  parameter int unsigned COLOR_W   = 8
);
  localparam int unsigned INSTR_W = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1;
  localparam int unsigned PAL_AW  = $clog2(NUM_INSTR + 3);

  logic                   pix_valid;
  logic [1:0]             pix_type;
  logic [INSTR_W-1:0]     instr;
  logic                   highlight;
  logic                   frame_start;
  logic                   pal_we;
  logic [PAL_AW-1:0]      pal_addr;
  logic [3*COLOR_W-1:0]   pal_wdata;
  logic                   out_valid;
  logic [COLOR_W-1:0]     r;
  logic [COLOR_W-1:0]     g;
  logic [COLOR_W-1:0]     b;

  modport master (
    output pix_valid, pix_type, instr, highlight, frame_start,
    output pal_we, pal_addr, pal_wdata,
    input  out_valid, r, g, b
  );

  modport slave (
    input  pix_valid, pix_type, instr, highlight, frame_start,
    input  pal_we, pal_addr, pal_wdata,
    output out_valid, r, g, b
  );
endinterface

// File: rtl/palette_regfile.sv
// Palette storage: NUM_INSTR+3 colour entries, one write port, one registered
// read port. Entries return to their default colours on reset.
module palette_regfile
  import score_disp_pkg::*;
#(
  parameter int unsigned NUM_INSTR = 4,
  parameter int unsigned COLOR_W   = 8,
  localparam int unsigned NUM_ENTRIES = NUM_INSTR + NUM_FIXED,
  localparam int unsigned PAL_AW      = $clog2(NUM_ENTRIES),
  localparam int unsigned DATA_W      = 3 * COLOR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [PAL_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [PAL_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [NUM_ENTRIES];
  logic [DATA_W-1:0] rdata_q;

  // Narrow an 8-bit-per-channel colour to COLOR_W bits by dropping LSBs.
  function automatic logic [DATA_W-1:0] scale(input logic [23:0] c);
    logic [7:0] r8, g8, b8;
    r8 = c[23:16] >> (8 - COLOR_W);
    g8 = c[15:8]  >> (8 - COLOR_W);
    b8 = c[7:0]   >> (8 - COLOR_W);
    return {r8[COLOR_W-1:0], g8[COLOR_W-1:0], b8[COLOR_W-1:0]};
  endfunction

  // Entry storage; out-of-range write addresses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        mem_q[i] <= scale(default_rgb24(i, NUM_INSTR));
      end
    end else if (we && (32'(waddr) < NUM_ENTRIES)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Registered read; a same-edge write is not forwarded, so the old value is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re && (32'(raddr) < NUM_ENTRIES)) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/color_palette_pipe.sv
// Pixel-to-RGB stage: resolves pixel class + instrument to a palette entry,
// looks it up in a programmable palette and blinks highlighted notes.
// Two-stage pipeline, one pixel per cycle, no backpressure.
module color_palette_pipe
  import score_disp_pkg::*;
#(
  parameter int unsigned NUM_INSTR    = 4,
  parameter int unsigned COLOR_W      = 8,
  parameter int unsigned BLINK_FRAMES = 15,
  localparam int unsigned INSTR_W = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1,
  localparam int unsigned PAL_AW  = $clog2(NUM_INSTR + NUM_FIXED),
  localparam int unsigned CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1,
  localparam int unsigned DATA_W  = 3 * COLOR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  color_palette_pipe_if.slave  bus
);

  logic [PAL_AW-1:0] idx_d;
  logic              v1_q;
  logic [PAL_AW-1:0] idx1_q;
  logic              hl1_q;
  logic              out_valid_q;
  logic              inv2_q;
  logic [CNT_W-1:0]  frame_cnt_q;
  logic              blink_phase_q;
  logic [DATA_W-1:0] pal_rdata;
  logic [DATA_W-1:0] rgb;

  // Resolve pixel class to a palette index; unknown instruments show background.
  always_comb begin
    idx_d = PAL_AW'(NUM_INSTR + BG_OFS);
    unique case (pix_type_e'(bus.pix_type))
      PixNote: begin
        if (32'(bus.instr) < NUM_INSTR) begin
          idx_d = PAL_AW'(bus.instr);
        end
      end
      PixStaff:      idx_d = PAL_AW'(NUM_INSTR + STAFF_OFS);
      PixCursor:     idx_d = PAL_AW'(NUM_INSTR + CURSOR_OFS);
      PixBackground: idx_d = PAL_AW'(NUM_INSTR + BG_OFS);
    endcase
  end

  // Stage 1: capture valid, index and the note-highlight flag every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      idx1_q <= '0;
      hl1_q  <= 1'b0;
    end else begin
      v1_q   <= bus.pix_valid;
      idx1_q <= idx_d;
      hl1_q  <= bus.highlight && (pix_type_e'(bus.pix_type) == PixNote);
    end
  end

  // Frame counter and blink phase, toggled every BLINK_FRAMES frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (bus.frame_start) begin
      if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  // Stage 2 colour register lives in the palette read port; it only loads
  // for valid pixels so r/g/b hold across invalid cycles.
  palette_regfile #(
    .NUM_INSTR (NUM_INSTR),
    .COLOR_W   (COLOR_W)
  ) u_palette (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bus.pal_we),
    .waddr (bus.pal_addr),
    .wdata (bus.pal_wdata),
    .re    (v1_q),
    .raddr (idx1_q),
    .rdata (pal_rdata)
  );

  // Stage 2 control: output valid and inversion flag, sampled with the colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      inv2_q      <= 1'b0;
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        inv2_q <= hl1_q && blink_phase_q;
      end
    end
  end

  // Inversion mux on registered colour and registered flag.
  always_comb begin
    rgb = inv2_q ? ~pal_rdata : pal_rdata;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.r         = rgb[3*COLOR_W-1 -: COLOR_W];
  assign bus.g         = rgb[2*COLOR_W-1 -: COLOR_W];
  assign bus.b         = rgb[COLOR_W-1 -: COLOR_W];

endmodule

// File: tb/tb_color_palette_pipe.sv
// Directed bench for color_palette_pipe: table of pixel vectors plus
// hand-written sequences for palette writes, blinking and reset.
module tb_color_palette_pipe;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  color_palette_pipe_if #(.NUM_INSTR(4), .COLOR_W(8)) bus ();
  color_palette_pipe_if #(.NUM_INSTR(6), .COLOR_W(8)) bus6 ();

  color_palette_pipe #(
    .NUM_INSTR    (4),
    .COLOR_W      (8),
    .BLINK_FRAMES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  color_palette_pipe #(
    .NUM_INSTR    (6),
    .COLOR_W      (8),
    .BLINK_FRAMES (2)
  ) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [1:0]  ptype;
    logic [1:0]  instr;
    logic        hl;
    logic        exp_valid;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t        vecs [9];
  vec_t        rd_vecs [7];
  logic [2:0]  instr6 [4];
  logic [23:0] exp6 [4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input logic v, input logic [1:0] t, input logic [1:0] ins,
                           input logic hl);
    bus.pix_valid = v;
    bus.pix_type  = t;
    bus.instr     = ins;
    bus.highlight = hl;
  endtask

  task automatic check_out(input string name, input logic ev, input logic [23:0] ergb);
    check({name, "_valid"}, 32'(bus.out_valid), 32'(ev));
    check({name, "_rgb"}, 32'({bus.r, bus.g, bus.b}), 32'(ergb));
  endtask

  task automatic frame_pulse();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{1'b1, 2'b00, 2'd1, 1'b0, 1'b1, 24'h00FF00};
    vecs[1] = '{1'b1, 2'b01, 2'd0, 1'b0, 1'b1, 24'hFFFFFF};
    vecs[2] = '{1'b1, 2'b10, 2'd0, 1'b0, 1'b1, 24'hFFFFFF};
    vecs[3] = '{1'b1, 2'b11, 2'd0, 1'b0, 1'b1, 24'h000000};
    vecs[4] = '{1'b1, 2'b00, 2'd0, 1'b0, 1'b1, 24'hFF0000};
    vecs[5] = '{1'b1, 2'b00, 2'd3, 1'b0, 1'b1, 24'hFFFF00};
    vecs[6] = '{1'b0, 2'b00, 2'd2, 1'b0, 1'b0, 24'hFFFF00};
    vecs[7] = '{1'b1, 2'b00, 2'd2, 1'b1, 1'b1, 24'h0000FF};
    vecs[8] = '{1'b1, 2'b01, 2'd0, 1'b1, 1'b1, 24'hFFFFFF};

    // Palette read-back after writing bg=102030 and an ignored write to addr 7.
    rd_vecs[0] = '{1'b1, 2'b00, 2'd0, 1'b0, 1'b1, 24'hFF0000};
    rd_vecs[1] = '{1'b1, 2'b00, 2'd1, 1'b0, 1'b1, 24'h00FF00};
    rd_vecs[2] = '{1'b1, 2'b00, 2'd2, 1'b0, 1'b1, 24'h0000FF};
    rd_vecs[3] = '{1'b1, 2'b00, 2'd3, 1'b0, 1'b1, 24'hFFFF00};
    rd_vecs[4] = '{1'b1, 2'b01, 2'd0, 1'b0, 1'b1, 24'hFFFFFF};
    rd_vecs[5] = '{1'b1, 2'b10, 2'd0, 1'b0, 1'b1, 24'hFFFFFF};
    rd_vecs[6] = '{1'b1, 2'b11, 2'd0, 1'b0, 1'b1, 24'h102030};

    instr6[0] = 3'd5; exp6[0] = 24'h00FFFF;
    instr6[1] = 3'd6; exp6[1] = 24'h000000;
    instr6[2] = 3'd4; exp6[2] = 24'hFF00FF;
    instr6[3] = 3'd7; exp6[3] = 24'h000000;

    rst_n           = 1'b0;
    drive_pix(1'b0, 2'b00, 2'd0, 1'b0);
    bus.frame_start = 1'b0;
    bus.pal_we      = 1'b0;
    bus.pal_addr    = '0;
    bus.pal_wdata   = '0;
    bus6.pix_valid  = 1'b0;
    bus6.pix_type   = 2'b00;
    bus6.instr      = '0;
    bus6.highlight  = 1'b0;
    bus6.frame_start = 1'b0;
    bus6.pal_we     = 1'b0;
    bus6.pal_addr   = '0;
    bus6.pal_wdata  = '0;

    // Reset state.
    #1;
    check_out("reset", 1'b0, 24'h000000);
    check("reset6_valid", 32'(bus6.out_valid), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Table: output of vector i-1 visible after the step that applies vector i.
    for (int i = 0; i <= 9; i++) begin
      if (i < 9) drive_pix(vecs[i].valid, vecs[i].ptype, vecs[i].instr, vecs[i].hl);
      else       drive_pix(1'b0, 2'b00, 2'd0, 1'b0);
      step();
      if (i >= 1) check_out($sformatf("vec%0d", i - 1), vecs[i-1].exp_valid, vecs[i-1].exp_rgb);
    end

    // In-range write to the last entry, then an out-of-range write.
    bus.pal_we    = 1'b1;
    bus.pal_addr  = 3'd6;
    bus.pal_wdata = 24'h102030;
    step();
    bus.pal_addr  = 3'd7;
    bus.pal_wdata = 24'hABCDEF;
    step();
    bus.pal_we    = 1'b0;
    for (int i = 0; i <= 7; i++) begin
      if (i < 7) drive_pix(rd_vecs[i].valid, rd_vecs[i].ptype, rd_vecs[i].instr, 1'b0);
      else       drive_pix(1'b0, 2'b00, 2'd0, 1'b0);
      step();
      if (i >= 1) check_out($sformatf("pal%0d", i - 1), 1'b1, rd_vecs[i-1].exp_rgb);
    end

    // Write entry 2 on the edge where an instr=2 pixel is read in stage 2.
    drive_pix(1'b1, 2'b00, 2'd2, 1'b0);
    step();
    bus.pal_we    = 1'b1;
    bus.pal_addr  = 3'd2;
    bus.pal_wdata = 24'h123456;
    step();
    check_out("wr_old", 1'b1, 24'h0000FF);
    bus.pal_we = 1'b0;
    drive_pix(1'b0, 2'b00, 2'd0, 1'b0);
    step();
    check_out("wr_new", 1'b1, 24'h123456);

    // Blink with BLINK_FRAMES=2 on a highlighted instrument-0 note.
    drive_pix(1'b1, 2'b00, 2'd0, 1'b1);
    step();
    step();
    check_out("blink_f0", 1'b1, 24'hFF0000);
    frame_pulse();
    step();
    step();
    check_out("blink_f1", 1'b1, 24'hFF0000);
    bus.frame_start = 1'b1;
    step();
    check_out("blink_edge_old", 1'b1, 24'hFF0000);
    bus.frame_start = 1'b0;
    step();
    check_out("blink_edge_new", 1'b1, 24'h00FFFF);
    drive_pix(1'b1, 2'b00, 2'd0, 1'b0);
    step();
    step();
    check_out("blink_nohl", 1'b1, 24'hFF0000);
    drive_pix(1'b1, 2'b01, 2'd0, 1'b1);
    step();
    step();
    check_out("blink_staff", 1'b1, 24'hFFFFFF);
    drive_pix(1'b1, 2'b00, 2'd0, 1'b1);
    frame_pulse();
    step();
    step();
    check_out("blink_f3", 1'b1, 24'h00FFFF);
    bus.frame_start = 1'b1;
    step();
    check_out("blink_edge4_old", 1'b1, 24'h00FFFF);
    bus.frame_start = 1'b0;
    step();
    check_out("blink_edge4_new", 1'b1, 24'hFF0000);

    // Asynchronous reset mid-stream restores outputs and palette defaults.
    drive_pix(1'b1, 2'b00, 2'd2, 1'b0);
    step();
    step();
    check_out("pre_reset", 1'b1, 24'h123456);
    #3;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 1'b0, 24'h000000);
    step();
    rst_n = 1'b1;
    step();
    step();
    check_out("post_reset", 1'b1, 24'h0000FF);
    drive_pix(1'b0, 2'b00, 2'd0, 1'b0);

    // Six-instrument instance: indices 6 and 7 are out of range.
    for (int i = 0; i <= 4; i++) begin
      bus6.pix_valid = (i < 4);
      bus6.pix_type  = 2'b00;
      bus6.instr     = (i < 4) ? instr6[i] : 3'd0;
      step();
      if (i >= 1) begin
        check($sformatf("n6_instr%0d_valid", instr6[i-1]), 32'(bus6.out_valid), 32'd1);
        check($sformatf("n6_instr%0d_rgb", instr6[i-1]), 32'({bus6.r, bus6.g, bus6.b}),
              32'(exp6[i-1]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
